// File: rtl/rf_arbiter.sv
// rf_arbiter: two-requester round-robin arbiter in front of a single-port
// register file.
//
// Ports
//   i_CLK, i_RST           clock, asynchronous active-high reset
//   i_{A,B}_WrEn/RdEn      level requests, held until the matching GNT
//   i_{A,B}_Address/WrData request address and write data
//   o_{A,B}_GNT            one-cycle pulse: transaction complete
//   o_{A,B}_RdData         last read result, held until that side's next read
//   o_{A,B}_RdData_Valid   one-cycle pulse alongside GNT on a read
//   o_WrEn/RdEn/Address/WrData, i_RdData/i_RdData_Valid  register-file side
//   o_TIMEOUT              one-cycle pulse when a read completes by timeout
//
// state | meaning
// IDLE  | arbitrate between pending requests
// WRITE | single-cycle write strobe to the register file, GNT to owner
// READ  | hold read enable/address until data valid or wait limit reached
// RESP  | return read data to owner with valid + GNT
module rf_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_A_WrEn,
  input  logic                  i_A_RdEn,
  input  logic [ADDR_WIDTH-1:0] i_A_Address,
  input  logic [DATA_WIDTH-1:0] i_A_WrData,
  output logic                  o_A_GNT,
  output logic [DATA_WIDTH-1:0] o_A_RdData,
  output logic                  o_A_RdData_Valid,
  input  logic                  i_B_WrEn,
  input  logic                  i_B_RdEn,
  input  logic [ADDR_WIDTH-1:0] i_B_Address,
  input  logic [DATA_WIDTH-1:0] i_B_WrData,
  output logic                  o_B_GNT,
  output logic [DATA_WIDTH-1:0] o_B_RdData,
  output logic                  o_B_RdData_Valid,
  output logic                  o_WrEn,
  output logic                  o_RdEn,
  output logic [ADDR_WIDTH-1:0] o_Address,
  output logic [DATA_WIDTH-1:0] o_WrData,
  input  logic [DATA_WIDTH-1:0] i_RdData,
  input  logic                  i_RdData_Valid,
  output logic                  o_TIMEOUT
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;   // 0 = A, 1 = B
  logic                  last_q, last_d;     // side granted last, 0 = A, 1 = B
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  a_gnt_q, a_gnt_d;
  logic                  b_gnt_q, b_gnt_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic                  timeout_q, timeout_d;

  logic                  a_req, b_req, win_b, sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [3:0]            cnt_inc;

  assign a_req     = i_A_WrEn | i_A_RdEn;
  assign b_req     = i_B_WrEn | i_B_RdEn;
  // B wins when alone, or on contention when A was granted last.
  assign win_b     = b_req & (~a_req | ~last_q);
  // Write takes precedence over a simultaneous read from the same side.
  assign sel_wr    = win_b ? i_B_WrEn    : i_A_WrEn;
  assign sel_addr  = win_b ? i_B_Address : i_A_Address;
  assign sel_wdata = win_b ? i_B_WrData  : i_A_WrData;
  // Wait limit compares the count including the current cycle, so the
  // READ state lasts at most TIMEOUT cycles.
  assign cnt_inc   = cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_req | b_req) begin
          owner_d = win_b;
          last_d  = win_b;
          addr_d  = sel_addr;
          cnt_d   = 4'd0;
          if (sel_wr) begin
            state_d = WRITE;
            wr_en_d = 1'b1;
            wdata_d = sel_wdata;
            a_gnt_d = ~win_b;
            b_gnt_d = win_b;
          end else begin
            state_d = READ;
            rd_en_d = 1'b1;
          end
        end
      end

      WRITE: state_d = IDLE;

      READ: begin
        cnt_d   = cnt_inc;
        rd_en_d = 1'b1;
        if (i_RdData_Valid) begin
          state_d = RESP;
          rd_en_d = 1'b0;
          if (owner_q) begin
            b_rdata_d  = i_RdData;
            b_rvalid_d = 1'b1;
            b_gnt_d    = 1'b1;
          end else begin
            a_rdata_d  = i_RdData;
            a_rvalid_d = 1'b1;
            a_gnt_d    = 1'b1;
          end
        end else if (cnt_inc == 4'(TIMEOUT)) begin
          state_d   = RESP;
          rd_en_d   = 1'b0;
          timeout_d = 1'b1;
          if (owner_q) begin
            b_rdata_d  = '0;
            b_rvalid_d = 1'b1;
            b_gnt_d    = 1'b1;
          end else begin
            a_rdata_d  = '0;
            a_rvalid_d = 1'b1;
            a_gnt_d    = 1'b1;
          end
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= 4'd0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_WrEn           = wr_en_q;
  assign o_RdEn           = rd_en_q;
  assign o_Address        = addr_q;
  assign o_WrData         = wdata_q;
  assign o_A_GNT          = a_gnt_q;
  assign o_B_GNT          = b_gnt_q;
  assign o_A_RdData       = a_rdata_q;
  assign o_B_RdData       = b_rdata_q;
  assign o_A_RdData_Valid = a_rvalid_q;
  assign o_B_RdData_Valid = b_rvalid_q;
  assign o_TIMEOUT        = timeout_q;

endmodule

// File: tb/tb_rf_arbiter.sv
// Bench for rf_arbiter: table of request scenarios feeding a scoreboard of
// expected transactions, plus hand sequences for latency and mid-read reset.
module tb_rf_arbiter;

  logic       clk = 1'b0;
  logic       i_RST;
  logic       i_A_WrEn, i_A_RdEn, i_B_WrEn, i_B_RdEn;
  logic [3:0] i_A_Address, i_B_Address;
  logic [7:0] i_A_WrData, i_B_WrData;
  logic       o_A_GNT, o_B_GNT, o_A_RdData_Valid, o_B_RdData_Valid;
  logic [7:0] o_A_RdData, o_B_RdData;
  logic       o_WrEn, o_RdEn, o_TIMEOUT;
  logic [3:0] o_Address;
  logic [7:0] o_WrData;
  logic [7:0] i_RdData;
  logic       i_RdData_Valid;

  always #5 clk = ~clk;

  rf_arbiter dut (
    .i_CLK(clk), .i_RST(i_RST),
    .i_A_WrEn(i_A_WrEn), .i_A_RdEn(i_A_RdEn), .i_A_Address(i_A_Address),
    .i_A_WrData(i_A_WrData), .o_A_GNT(o_A_GNT), .o_A_RdData(o_A_RdData),
    .o_A_RdData_Valid(o_A_RdData_Valid),
    .i_B_WrEn(i_B_WrEn), .i_B_RdEn(i_B_RdEn), .i_B_Address(i_B_Address),
    .i_B_WrData(i_B_WrData), .o_B_GNT(o_B_GNT), .o_B_RdData(o_B_RdData),
    .o_B_RdData_Valid(o_B_RdData_Valid),
    .o_WrEn(o_WrEn), .o_RdEn(o_RdEn), .o_Address(o_Address), .o_WrData(o_WrData),
    .i_RdData(i_RdData), .i_RdData_Valid(i_RdData_Valid), .o_TIMEOUT(o_TIMEOUT)
  );

  typedef struct {
    logic       owner_b;
    logic       is_wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       tmo;
    int         rd_cycles;
    int         gap;
  } exp_t;

  typedef struct {
    logic       a_wr, a_rd;
    logic [3:0] a_addr;
    logic [7:0] a_data;
    logic       b_wr, b_rd;
    logic [3:0] b_addr;
    logic [7:0] b_data;
    int         delay;        // READ cycles before valid is driven, -1 = never
    logic [7:0] rdata;
    logic       stray;        // hold i_RdData_Valid high outside READ
    logic       exp_first_b;  // expected first winner
  } vec_t;

  exp_t       sb[$];
  int         n_pass = 0, n_total = 0;
  int         cyc = 0, last_gnt_cyc = 0, rd_seen = 0;
  int         resp_delay = -1;
  logic [7:0] resp_data = 8'h00;
  logic       stray_valid = 1'b0;
  logic [7:0] exp_a_rdata = 8'h00, exp_b_rdata = 8'h00;
  vec_t       vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  function automatic exp_t make_item(input logic ob, input logic wr, input logic [3:0] addr,
                                     input logic [7:0] data, input int delay,
                                     input logic [7:0] rdata, input bit second);
    exp_t e;
    e.owner_b   = ob;
    e.is_wr     = wr;
    e.addr      = addr;
    e.wdata     = data;
    e.tmo       = (delay < 0);
    e.rdata     = (delay < 0) ? 8'h00 : rdata;
    e.rd_cycles = (delay < 0) ? 15 : delay + 1;
    e.gap       = !second ? -1 : (wr ? 2 : e.rd_cycles + 2);
    return e;
  endfunction

  // One clock: monitor/scoreboard, requester drop on GNT, register-file responder.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    check("pulse_without_gnt",
          {30'd0, o_A_RdData_Valid & ~o_A_GNT, o_B_RdData_Valid & ~o_B_GNT}
          | {28'd0, o_TIMEOUT & ~(o_A_GNT | o_B_GNT), o_A_GNT & o_B_GNT, 2'b00}, 0);
    if (o_RdEn && sb.size() > 0) check("rd_addr", o_Address, sb[0].addr);
    if (o_A_GNT | o_B_GNT) begin
      if (sb.size() == 0) begin
        check("gnt_unexpected", {o_A_GNT, o_B_GNT}, 0);
      end else begin
        e = sb.pop_front();
        check("gnt_owner", {o_A_GNT, o_B_GNT}, e.owner_b ? 2'b01 : 2'b10);
        if (e.gap >= 0) check("gnt_gap", cyc - last_gnt_cyc, e.gap);
        if (e.is_wr) begin
          check("wr_en", {o_WrEn, o_RdEn}, 2'b10);
          check("wr_addr", o_Address, e.addr);
          check("wr_data", o_WrData, e.wdata);
          check("wr_no_valid", {o_A_RdData_Valid, o_B_RdData_Valid, o_TIMEOUT}, 0);
        end else begin
          check("rd_valid", {o_A_RdData_Valid, o_B_RdData_Valid}, e.owner_b ? 2'b01 : 2'b10);
          check("rd_data", e.owner_b ? o_B_RdData : o_A_RdData, e.rdata);
          check("rd_timeout", o_TIMEOUT, e.tmo);
          check("rd_cycles", rd_seen, e.rd_cycles);
          check("rd_en_low", {o_WrEn, o_RdEn}, 0);
          if (e.owner_b) exp_b_rdata = e.rdata;
          else           exp_a_rdata = e.rdata;
        end
        if (e.owner_b) check("a_rdata_hold", o_A_RdData, exp_a_rdata);
        else           check("b_rdata_hold", o_B_RdData, exp_b_rdata);
        if (e.owner_b) {i_B_WrEn, i_B_RdEn} = 2'b00;
        else           {i_A_WrEn, i_A_RdEn} = 2'b00;
      end
      last_gnt_cyc = cyc;
    end
    if (o_RdEn) begin
      i_RdData_Valid = stray_valid || (resp_delay >= 0 && rd_seen == resp_delay);
      i_RdData       = resp_data;
      rd_seen++;
    end else begin
      i_RdData_Valid = stray_valid;
      rd_seen        = 0;
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    if (sb.size() != 0) begin
      check("txn_done_pending", sb.size(), 0);
      sb.delete();
      {i_A_WrEn, i_A_RdEn, i_B_WrEn, i_B_RdEn} = 4'b0000;
    end
    tick();
  endtask

  task automatic apply_vec(input vec_t v);
    logic both;
    i_A_WrEn = v.a_wr; i_A_RdEn = v.a_rd; i_A_Address = v.a_addr; i_A_WrData = v.a_data;
    i_B_WrEn = v.b_wr; i_B_RdEn = v.b_rd; i_B_Address = v.b_addr; i_B_WrData = v.b_data;
    resp_delay = v.delay; resp_data = v.rdata;
    stray_valid = v.stray; i_RdData_Valid = v.stray;
    both = (v.a_wr | v.a_rd) & (v.b_wr | v.b_rd);
    if (v.exp_first_b) begin
      sb.push_back(make_item(1'b1, v.b_wr, v.b_addr, v.b_data, v.delay, v.rdata, 1'b0));
      if (both) sb.push_back(make_item(1'b0, v.a_wr, v.a_addr, v.a_data, v.delay, v.rdata, 1'b1));
    end else begin
      sb.push_back(make_item(1'b0, v.a_wr, v.a_addr, v.a_data, v.delay, v.rdata, 1'b0));
      if (both) sb.push_back(make_item(1'b1, v.b_wr, v.b_addr, v.b_data, v.delay, v.rdata, 1'b1));
    end
    wait_done();
    stray_valid = 1'b0;
  endtask

  initial begin
    //          a_wr a_rd a_addr a_data  b_wr b_rd b_addr b_data  delay rdata  stray first_b
    vecs[0] = '{1'b1, 1'b0, 4'h1, 8'h11, 1'b1, 1'b0, 4'h2, 8'h22, -1, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 4'h4, 8'h44, 1'b1, 1'b0, 4'h5, 8'h55, -1, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 4'h3, 8'h5A, 1'b0, 1'b0, 4'h0, 8'h00, -1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h7, 8'h00,  2, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 4'h9, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, -1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 4'h6, 8'h66, 1'b0, 1'b0, 4'h0, 8'h00,  0, 8'hAA, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 4'hA, 8'h00, 1'b1, 1'b0, 4'hB, 8'hBB,  0, 8'h81, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'hF, 8'h00, 14, 8'hE7, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 4'h1, 8'h00, 1'b0, 1'b1, 4'h2, 8'h00,  1, 8'h99, 1'b0, 1'b0};

    i_RST = 1'b1;
    {i_A_WrEn, i_A_RdEn, i_B_WrEn, i_B_RdEn} = 4'b0000;
    i_A_Address = 4'h0; i_B_Address = 4'h0; i_A_WrData = 8'h00; i_B_WrData = 8'h00;
    i_RdData = 8'h00; i_RdData_Valid = 1'b0;
    tick();
    tick();
    check("reset_ctrl", {o_WrEn, o_RdEn, o_A_GNT, o_B_GNT,
                         o_A_RdData_Valid, o_B_RdData_Valid, o_TIMEOUT}, 0);
    check("reset_addr_data", {o_Address, o_WrData}, 0);
    check("reset_rdata", {o_A_RdData, o_B_RdData}, 0);
    i_RST = 1'b0;

    for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

    // Write latency: request driven in IDLE, GNT exactly one edge later, one cycle wide.
    i_A_WrEn = 1'b1; i_A_Address = 4'hC; i_A_WrData = 8'hC3;
    sb.push_back(make_item(1'b0, 1'b1, 4'hC, 8'hC3, -1, 8'h00, 1'b0));
    tick();
    check("lat_write_strobe", {o_WrEn, o_A_GNT, o_B_GNT}, 3'b110);
    check("lat_write_addr_data", {o_Address, o_WrData}, {4'hC, 8'hC3});
    tick();
    check("lat_write_pulse_end", {o_WrEn, o_A_GNT}, 2'b00);

    // Reset in the middle of a read aborts it; pending B write then proceeds.
    resp_delay = -1;
    i_A_RdEn = 1'b1; i_A_Address = 4'h5;
    sb.push_back(make_item(1'b0, 1'b0, 4'h5, 8'h00, -1, 8'h00, 1'b0));
    for (int i = 0; i < 4; i++) tick();
    i_B_WrEn = 1'b1; i_B_Address = 4'hD; i_B_WrData = 8'hD5;
    sb.push_back(make_item(1'b1, 1'b1, 4'hD, 8'hD5, -1, 8'h00, 1'b0));
    tick();
    check("nonowner_ignored", {o_RdEn, o_B_GNT, o_A_GNT}, 3'b100);
    #2 i_RST = 1'b1;
    #1;
    check("async_reset_rden", {o_RdEn, o_A_GNT, o_Address}, 0);
    i_A_RdEn = 1'b0;
    void'(sb.pop_front());
    exp_a_rdata = 8'h00;
    exp_b_rdata = 8'h00;
    tick();
    check("reset_rdata_cleared", {o_A_RdData, o_B_RdData}, 0);
    i_RST = 1'b0;
    tick();
    check("post_reset_b_gnt", {o_B_GNT, o_WrEn, o_Address, o_WrData}, {1'b1, 1'b1, 4'hD, 8'hD5});
    wait_done();

    check("scoreboard_empty", sb.size(), 0);
    check("final_rdata", {o_A_RdData, o_B_RdData}, {exp_a_rdata, exp_b_rdata});
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rf_arbiter.md
RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, data width; ADDR_WIDTH, default 4, register-file address width; TIMEOUT, default 15, maximum read-wait cycles.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_CLK  in  1  single clock.
- i_RST  in  1  reset, asynchronous, active-high.
- i_A_WrEn, i_A_RdEn  in  1 each  requester A write/read request.
- i_A_Address  in  ADDR_WIDTH  requester A address.
- i_A_WrData  in  DATA_WIDTH  requester A write data.
- o_A_GNT  out  1  requester A transaction done, one-cycle pulse.
- o_A_RdData  out  DATA_WIDTH  requester A read data.
- o_A_RdData_Valid  out  1  requester A read-data valid pulse.
- i_B_*, o_B_*: identical set for requester B.
- o_WrEn, o_RdEn  out  1 each  register-file write/read enable.
- o_Address  out  ADDR_WIDTH  register-file address.
- o_WrData  out  DATA_WIDTH  register-file write data.
- i_RdData  in  DATA_WIDTH  register-file read data.
- i_RdData_Valid  in  1  register-file read-data valid.
- o_TIMEOUT  out  1  read timed out, one-cycle pulse.
REQ-003 Every output SHALL be driven from a register.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, WRITE, READ, RESP.
REQ-005 A request SHALL be a level; the requester holds WrEn/RdEn, Address and WrData stable until it sees its GNT.
REQ-006 In IDLE, if one requester has a request, it SHALL win; if both do, the requester not granted last SHALL win (round-robin).
REQ-007 The winner SHALL be recorded as the owner.
REQ-008 The last-granted pointer SHALL update when the owner is recorded.
REQ-009 If a requester asserts WrEn and RdEn together, the write SHALL be serviced and the read ignored for that arbitration.
REQ-010 IDLE->WRITE on a write win: for exactly one cycle, o_WrEn=1, o_Address and o_WrData = owner's values, owner GNT=1; then the FSM SHALL go to IDLE.
REQ-011 IDLE->READ on a read win: o_RdEn=1 and o_Address = owner's address SHALL be held every READ cycle.
REQ-012 In READ, a 4-bit wait counter SHALL clear on entry and increment each cycle.
REQ-013 READ->RESP when i_RdData_Valid=1: the arbiter SHALL capture i_RdData into the owner's o_x_RdData.
REQ-014 READ->RESP when the counter reaches TIMEOUT without i_RdData_Valid: the owner's o_x_RdData SHALL be loaded with 0 and o_TIMEOUT SHALL pulse during RESP.
REQ-015 In RESP, for one cycle: owner's o_x_RdData_Valid=1 and GNT=1; then the FSM SHALL go to IDLE.
REQ-016 o_x_RdData SHALL hold its value until the next read for that requester.
REQ-017 Write latency SHALL be 1 cycle from request sampled in IDLE to GNT.
REQ-018 Read latency SHALL be (cycles in READ)+1 cycles.
REQ-019 A new arbitration SHALL NOT start in the cycle GNT is asserted.
REQ-020 The minimum inter-transaction gap SHALL be one IDLE cycle.
REQ-021 The non-owner's request SHALL be ignored until IDLE, then arbitrated normally.
REQ-022 Requests changing during WRITE, READ or RESP SHALL NOT affect the current transaction.
REQ-023 i_RdData_Valid outside READ SHALL be ignored.
REQ-024 i_RdData_Valid and timeout in the same cycle: valid data SHALL win and o_TIMEOUT SHALL stay 0.
REQ-025 The non-owner's GNT and RdData_Valid SHALL remain 0 throughout a transaction.

Reset
REQ-026 While i_RST=1, independent of i_CLK, the arbiter SHALL force: state IDLE; all enables, GNTs, valids and o_TIMEOUT 0; o_Address, o_WrData, o_A_RdData, o_B_RdData 0; wait counter 0; last-granted = B, so A wins the first contention.
REQ-027 Reset asserted mid-transaction SHALL abort it with no GNT issued.
REQ-028 After reset release, arbitration SHALL resume on the first rising edge with a request present.

Verification
REQ-029 A write only, addr 3, data 0x5A -> next cycle o_WrEn=1, o_Address=3, o_WrData=0x5A, o_A_GNT=1 for one cycle, B outputs 0.
REQ-030 Both request after reset -> A served first, then B after one IDLE cycle; repeated simultaneous requests alternate A, B, A, B.
REQ-031 B read addr 7, i_RdData_Valid=1 with 0x3C after 2 READ cycles -> o_B_RdData=0x3C, o_B_RdData_Valid and o_B_GNT pulse together one cycle, o_TIMEOUT=0.
REQ-032 A read, i_RdData_Valid never asserted -> after 15 READ cycles, RESP with o_A_RdData=0, o_A_RdData_Valid=1, o_TIMEOUT=1, then IDLE.
REQ-033 i_RST=1 during READ -> o_RdEn falls to 0 immediately without a clock edge, no GNT; after release, a pending B request is granted normally.
REQ-034 A asserts WrEn and RdEn together -> write performed, A GNT pulses, no read issued.
